// File: rtl/conv_pkg.sv
// Shared types and sizing for the convolution accelerator output side.
// Default geometry: 15x13 input, kernels up to 7x7, 24-bit results.
package conv_pkg;

    localparam int OUTW_DEF  = 24;
    localparam int R_DEF     = 15;
    localparam int C_DEF     = 13;
    localparam int MAXK_DEF  = 7;
    localparam int DEPTH_DEF = 8;

    localparam int K_BITS   = $clog2(MAXK_DEF + 1);
    localparam int CNT_BITS = $clog2(R_DEF * C_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } out_state_t;

    // Number of valid output positions; a zero kernel acts as 1x1.
    function automatic int unsigned out_total(
        input int unsigned r,
        input int unsigned c,
        input int unsigned k
    );
        int unsigned kk;
        kk = (k == 0) ? 1 : k;
        return (r - kk + 1) * (c - kk + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head output; dout is valid whenever
// the FIFO is not empty. Push-when-full and pop-when-empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [AW:0]      rd_nxt;
    logic [AW:0]      count;
    logic [WIDTH-1:0] dout_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_nxt  = rd_q + (AW+1)'(1);
    assign count   = wr_q - rd_q;
    assign dout    = dout_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

    // Head register follows the oldest entry; a lone pushed word
    // goes straight into it so it is visible one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            dout_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_nxt;
            end
            if (push_ok && (empty ||
                (pop_ok && count == (AW+1)'(1)))) begin
                dout_q <= din;
            end else if (pop_ok && count > (AW+1)'(1)) begin
                dout_q <= mem_q[rd_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/output_stream.sv
// AXI-Stream transmit side of the convolution accelerator.
// Build option: OUTPUT_RELU_EN clamps negative results to zero.
import conv_pkg::*;

module output_stream #(
    parameter int OUTW  = OUTW_DEF,
    parameter int R     = R_DEF,
    parameter int C     = C_DEF,
    parameter int MAXK  = MAXK_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inputs_loaded,
    input  logic [$clog2(MAXK+1)-1:0] K,
    input  logic [OUTW-1:0]           in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [OUTW-1:0]           AXIS_TDATA,
    output logic                      AXIS_TVALID,
    input  logic                      AXIS_TREADY,
    output logic                      AXIS_TLAST,
    output logic                      compute_finished
);

    localparam int CW = $clog2(R * C + 1);

    out_state_t      state_q;
    logic [CW-1:0]   total_q;
    logic [CW-1:0]   total_d;
    logic [CW-1:0]   acc_q;
    logic [CW-1:0]   sent_q;
    logic            wait_clr_q;

    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [OUTW-1:0] wdata;
    logic [OUTW-1:0] dout;

`ifdef OUTPUT_RELU_EN
    assign wdata = in_data[OUTW-1] ? '0 : in_data;
`else
    assign wdata = in_data;
`endif

    assign total_d = CW'(out_total(R, C, int'(K)));

    assign in_ready    = (state_q == STREAM) && !full &&
                         (acc_q < total_q);
    assign push        = in_valid && in_ready;
    assign AXIS_TVALID = (state_q == STREAM) && !empty;
    assign pop         = AXIS_TVALID && AXIS_TREADY;
    assign AXIS_TLAST  = AXIS_TVALID &&
                         (sent_q == total_q - CW'(1));
    assign AXIS_TDATA  = dout;

    assign compute_finished = (state_q == DONE);

    sync_fifo #(
        .WIDTH (OUTW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wdata),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    // wait_clr_q blocks a restart until inputs_loaded has dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            total_q    <= '0;
            acc_q      <= '0;
            sent_q     <= '0;
            wait_clr_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!inputs_loaded) begin
                        wait_clr_q <= 1'b0;
                    end else if (!wait_clr_q) begin
                        total_q <= total_d;
                        acc_q   <= '0;
                        sent_q  <= '0;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (push) begin
                        acc_q <= acc_q + CW'(1);
                    end
                    if (pop) begin
                        sent_q <= sent_q + CW'(1);
                    end
                    if (pop && AXIS_TLAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    wait_clr_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_stream.sv
// Scoreboard bench for output_stream: directed runs plus a random
// handshake run; results are checked as beats leave the AXIS port.
module tb_output_stream;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inputs_loaded;
    logic [2:0]  K;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        cf;

    always #5 clk = ~clk;

    output_stream dut (
        .clk              (clk),
        .reset            (reset),
        .inputs_loaded    (inputs_loaded),
        .K                (K),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .AXIS_TDATA       (tdata),
        .AXIS_TVALID      (tvalid),
        .AXIS_TREADY      (tready),
        .AXIS_TLAST       (tlast),
        .compute_finished (cf)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          beats = 0;
    int          pushes = 0;
    int          tlast_cnt = 0;
    int          cf_cnt = 0;
    int          exp_total = 0;
    logic [23:0] sbq[$];
    bit          gen_en = 0;
    bit          rnd = 0;
    bit          acc_seen = 0;
    bit          exp_cf = 0;
    bit          prev_stall = 0;
    logic [23:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [23:0] pat = 24'h000100;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] model(input logic [23:0] d);
`ifdef OUTPUT_RELU_EN
        return d[23] ? 24'd0 : d;
`else
        return d;
`endif
    endfunction

    // Monitor: push expectations on accept, compare on AXIS beats.
    always @(negedge clk) begin
        if (reset) begin
            acc_seen   = 0;
            exp_cf     = 0;
            prev_stall = 0;
        end else begin
            if (cf) cf_cnt++;
            chk("compute_finished", 32'(cf), 32'(exp_cf));
            exp_cf = 0;
            if (exp_total != 0 && pushes == exp_total)
                chk("in_ready_after_total", 32'(in_ready), 32'd0);
            if (prev_stall) begin
                chk("tvalid_hold", 32'(tvalid), 32'd1);
                chk("tdata_hold", 32'(tdata), 32'(prev_data));
                chk("tlast_hold", 32'(tlast), 32'(prev_last));
            end
            acc_seen = in_valid && in_ready;
            if (acc_seen) begin
                sbq.push_back(model(in_data));
                pushes++;
            end
            if (tvalid && tready) begin
                beats++;
                if (sbq.size() == 0)
                    chk("sb_underflow", 32'(sbq.size() == 0), 32'd0);
                else
                    chk("tdata", 32'(tdata), 32'(sbq.pop_front()));
                chk("tlast", 32'(tlast), 32'(beats == exp_total));
                if (tlast) begin
                    tlast_cnt++;
                    exp_cf = 1;
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // Stimulus generator: next pattern value after each accept.
    always @(posedge clk) begin
        #1;
        if (acc_seen) pat = pat + 24'd1;
        if (gen_en) begin
            in_data  = pat;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rnd) tready = 1'($urandom_range(0, 1));
    end

    task automatic start_run(input int k, input int n);
        exp_total = n;
        beats     = 0;
        pushes    = 0;
        tlast_cnt = 0;
        cf_cnt    = 0;
        sbq.delete();
        K             = 3'(k);
        inputs_loaded = 1'b1;
    endtask

    task automatic finish_run(input string tag, input int lim);
        int cyc = 0;
        while (cf_cnt == 0 && cyc < lim) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(cyc < lim), 32'd1);
        inputs_loaded = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_beats"}, 32'(beats), 32'(exp_total));
        chk({tag, "_pushes"}, 32'(pushes), 32'(exp_total));
        chk({tag, "_tlast_cnt"}, 32'(tlast_cnt), 32'd1);
        chk({tag, "_cf_cnt"}, 32'(cf_cnt), 32'd1);
        chk({tag, "_sb_left"}, 32'(sbq.size()), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_idle_tvalid"}, 32'(tvalid), 32'd0);
    endtask

    initial begin
        logic [23:0] first;
        int          cyc;
        reset         = 1'b1;
        inputs_loaded = 1'b0;
        K             = 3'd0;
        in_data       = '0;
        in_valid      = 1'b0;
        tready        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_cf", 32'(cf), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // K=3 full-rate run
        gen_en = 1;
        start_run(3, 143);
        finish_run("k3", 2000);

        // K=7: extra in_valid beyond 63 never accepted
        start_run(7, 63);
        finish_run("k7", 2000);

        // Downstream stall fills the FIFO
        tready = 1'b0;
        first  = pat;
        start_run(3, 143);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_pushes", 32'(pushes), 32'd8);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_tvalid", 32'(tvalid), 32'd1);
        chk("stall_tdata", 32'(tdata), 32'(model(first)));
        tready = 1'b1;
        finish_run("stall", 2000);

        // Single negative word into an empty FIFO
        gen_en   = 0;
        in_valid = 1'b0;
        start_run(3, 143);
        repeat (3) @(posedge clk);
        #1;
        in_data  = 24'hFFFFFB;
        in_valid = 1'b1;
        @(negedge clk);
        chk("neg_in_ready", 32'(in_ready), 32'd1);
        chk("neg_no_bypass", 32'(tvalid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("neg_tvalid", 32'(tvalid), 32'd1);
        chk("neg_tdata", 32'(tdata), 32'(model(24'hFFFFFB)));
        @(posedge clk);
        #1;
        gen_en = 1;
        finish_run("neg", 2000);

        // Reset after 50 beats, then a clean full run
        start_run(3, 143);
        cyc = 0;
        while (beats < 50 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("mid_reach50", 32'(cyc < 2000), 32'd1);
        reset         = 1'b1;
        inputs_loaded = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_tvalid", 32'(tvalid), 32'd0);
        chk("mid_tlast", 32'(tlast), 32'd0);
        chk("mid_tdata", 32'(tdata), 32'd0);
        chk("mid_cf", 32'(cf), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_cf", 32'(cf_cnt), 32'd0);
        chk("mid_no_tlast", 32'(tlast_cnt), 32'd0);
        start_run(3, 143);
        finish_run("after_rst", 2000);

        // Random handshakes on both sides, K=1
        rnd = 1;
        start_run(1, 195);
        finish_run("rand", 6000);
        rnd    = 0;
        tready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
